// File: rtl/tiny_rv_pkg.sv
// rtl/tiny_rv_pkg.sv - shared types and helpers for the fetch controller
package tiny_rv_pkg;

    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        PEND  = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } fetch_ctrl_state_e;

    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_TRAP   = 3'd1,
        SRC_BR     = 3'd2,
        SRC_JAL    = 3'd3,
        SRC_RESUME = 3'd4
    } redir_src_e;

    // Resume outranks everything so a parked resume can never be displaced.
    function automatic logic [2:0] src_prio(input redir_src_e s);
        case (s)
            SRC_RESUME: src_prio = 3'd4;
            SRC_TRAP:   src_prio = 3'd3;
            SRC_BR:     src_prio = 3'd2;
            SRC_JAL:    src_prio = 3'd1;
            default:    src_prio = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/tiny_rv_redirect_arb.sv
// rtl/tiny_rv_redirect_arb.sv - fixed-priority select of trap, branch and jal redirects
module tiny_rv_redirect_arb
    import tiny_rv_pkg::*;
(
    input  logic        trap_valid_i,
    input  logic [31:0] trap_vec_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jal_valid_i,
    input  logic [31:0] jal_target_i,
    output logic        valid_o,
    output redir_src_e  src_o,
    output logic [31:0] target_o
);

    always_comb begin
        valid_o  = 1'b1;
        src_o    = SRC_NONE;
        target_o = '0;
        if (trap_valid_i) begin
            src_o    = SRC_TRAP;
            target_o = trap_vec_i;
        end else if (br_taken_i) begin
            src_o    = SRC_BR;
            target_o = br_target_i;
        end else if (jal_valid_i) begin
            src_o    = SRC_JAL;
            target_o = jal_target_i;
        end else begin
            valid_o  = 1'b0;
        end
    end

endmodule

// File: rtl/tiny_rv_fetch_ctrl.sv
// rtl/tiny_rv_fetch_ctrl.sv - fetch sequencing: boot PC, redirects, stall/flush, debug halt
module tiny_rv_fetch_ctrl
    import tiny_rv_pkg::*;
#(
    parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_trap_valid,
    input  logic [31:0]      i_trap_vec,
    input  logic             i_br_taken,
    input  logic [31:0]      i_br_target,
    input  logic             i_jal_valid,
    input  logic [31:0]      i_jal_target,
    input  logic             i_hazard_stall,
    input  logic             i_mem_busy,
    input  logic             i_halt_req,
    input  logic             i_resume_req,
    input  logic [31:0]      i_resume_addr,
    output logic             o_pipe_stall,
    output logic             o_pipe_flush,
    output logic             o_ld_new_addr,
    output logic [31:0]      o_new_addr,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_redirect_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_EXTRA = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    fetch_ctrl_state_e       state_q, state_d;
    redir_src_e              pend_src_q, pend_src_d;
    logic [31:0]             pend_addr_q, pend_addr_d;
    logic                    ld_q, ld_d;
    logic [31:0]             addr_q, addr_d;
    logic                    flush_q, flush_d;
    logic [FLUSH_CNT_W-1:0]  fcnt_q, fcnt_d;
    logic                    halted_q, halted_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    arb_valid;
    redir_src_e              arb_src;
    logic [31:0]             arb_target;
    logic                    issue;
    logic [31:0]             issue_addr;

    tiny_rv_redirect_arb u_arb (
        .trap_valid_i (i_trap_valid),
        .trap_vec_i   (i_trap_vec),
        .br_taken_i   (i_br_taken),
        .br_target_i  (i_br_target),
        .jal_valid_i  (i_jal_valid),
        .jal_target_i (i_jal_target),
        .valid_o      (arb_valid),
        .src_o        (arb_src),
        .target_o     (arb_target)
    );

    always_comb begin
        state_d     = state_q;
        pend_src_d  = pend_src_q;
        pend_addr_d = pend_addr_q;
        ld_d        = 1'b0;
        addr_d      = addr_q;
        flush_d     = 1'b0;
        fcnt_d      = fcnt_q;
        halted_d    = halted_q;
        cnt_d       = cnt_q;
        issue       = 1'b0;
        issue_addr  = '0;

        case (state_q)
            BOOT: begin
                if (!i_mem_busy) begin
                    ld_d    = 1'b1;
                    addr_d  = RESET_VEC;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (arb_valid) begin
                    if (i_mem_busy) begin
                        pend_src_d  = arb_src;
                        pend_addr_d = arb_target;
                        state_d     = PEND;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = arb_target;
                    end
                end else if (i_halt_req) begin
                    state_d  = HALT;
                    flush_d  = 1'b1;
                    halted_d = 1'b1;
                end
            end
            PEND: begin
                // A new request only displaces the parked one if it strictly outranks it.
                if (arb_valid && (src_prio(arb_src) > src_prio(pend_src_q))) begin
                    pend_src_d  = arb_src;
                    pend_addr_d = arb_target;
                end
                if (!i_mem_busy) begin
                    issue      = 1'b1;
                    issue_addr = pend_addr_d;
                end
            end
            FLUSH: begin
                if (i_trap_valid) begin
                    if (i_mem_busy) begin
                        pend_src_d  = SRC_TRAP;
                        pend_addr_d = i_trap_vec;
                        state_d     = PEND;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = i_trap_vec;
                    end
                end else begin
                    flush_d = 1'b1;
                    fcnt_d  = fcnt_q - 1'b1;
                    if (fcnt_q == FLUSH_CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                if (i_resume_req) begin
                    if (i_mem_busy) begin
                        pend_src_d  = SRC_RESUME;
                        pend_addr_d = i_resume_addr;
                        state_d     = PEND;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = i_resume_addr;
                    end
                end
            end
            default: state_d = BOOT;
        endcase

        // The final flush cycle is spent in RUN so a new redirect can be accepted there.
        if (issue) begin
            ld_d       = 1'b1;
            addr_d     = issue_addr;
            flush_d    = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            halted_d   = 1'b0;
            pend_src_d = SRC_NONE;
            fcnt_d     = FLUSH_EXTRA;
            state_d    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= BOOT;
            pend_src_q  <= SRC_NONE;
            pend_addr_q <= '0;
            ld_q        <= 1'b0;
            addr_q      <= RESET_VEC;
            flush_q     <= 1'b0;
            fcnt_q      <= '0;
            halted_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_src_q  <= pend_src_d;
            pend_addr_q <= pend_addr_d;
            ld_q        <= ld_d;
            addr_q      <= addr_d;
            flush_q     <= flush_d;
            fcnt_q      <= fcnt_d;
            halted_q    <= halted_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_pipe_stall   = !ld_q && (((state_q == RUN) && (i_hazard_stall || i_mem_busy))
                                      || (state_q == PEND) || (state_q == HALT));
    assign o_pipe_flush   = flush_q;
    assign o_ld_new_addr  = ld_q;
    assign o_new_addr     = addr_q;
    assign o_halted       = halted_q;
    assign o_redirect_cnt = cnt_q;

endmodule
